uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
//==============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO that sits between the console output path and a UART
//               transmitter. Writes are queued in a circular buffer. A small
//               drain FSM launches one byte at a time downstream and waits for
//               the transmitter to go busy, finish, and release its done flag
//               before it launches the next byte.
//
// Ports       : i_Clock      - single clock, rising edge
//               i_Reset_n    - synchronous active-low reset
//               i_Wr_En      - one-cycle byte write strobe
//               i_Wr_Byte    - byte written when i_Wr_En=1
//               o_Full       - count == DEPTH
//               o_Empty      - count == 0
//               o_Count      - number of stored bytes
//               o_Overflow   - sticky, set when a write is dropped
//               o_Tx_DV      - one-cycle launch strobe to the transmitter
//               o_Tx_Byte    - byte launched with o_Tx_DV, held until the next
//               i_Tx_Active  - transmitter busy
//               i_Tx_Done    - transmitter completion (may last several cycles)
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Wr_En,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    localparam logic [1:0] c_S_IDLE        = 2'd0;
    localparam logic [1:0] c_S_WAIT_ACTIVE = 2'd1;
    localparam logic [1:0] c_S_WAIT_DONE   = 2'd2;
    localparam logic [1:0] c_S_WAIT_CLEAR  = 2'd3;

    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_state;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_pop;

    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_empty = (r_count == '0);

    // Writes are refused while full, even if a pop happens in the same cycle,
    // so the full flag alone decides acceptance. Writes during reset are ignored.
    assign w_wr_accept = i_Reset_n && i_Wr_En && !w_full;

    // A launch needs the transmitter fully quiet: not busy and no lingering
    // done from a previous frame (which also covers a frame still in flight
    // across our own reset).
    assign w_pop = (r_state == c_S_IDLE) && !w_empty && !i_Tx_Active && !i_Tx_Done;

    assign o_Full  = w_full;
    assign o_Empty = w_empty;
    assign o_Count = r_count;

    // Storage array carries no reset; its contents are only meaningful
    // between the pointers.
    always_ff @(posedge i_Clock) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_Wr_Byte;
        end
    end

    // Pointers, count and overflow flag.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_Wr_En && w_full) begin
                o_Overflow <= 1'b1;
            end
        end
    end

    // Drain FSM with registered launch outputs.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_state   <= c_S_IDLE;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
        end else begin
            o_Tx_DV <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_pop) begin
                        o_Tx_Byte <= r_mem[r_rd_ptr];
                        o_Tx_DV   <= 1'b1;
                        r_state   <= c_S_WAIT_ACTIVE;
                    end
                end
                c_S_WAIT_ACTIVE: begin
                    if (i_Tx_Active) begin
                        r_state <= c_S_WAIT_DONE;
                    end
                end
                c_S_WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        r_state <= c_S_WAIT_CLEAR;
                    end
                end
                c_S_WAIT_CLEAR: begin
                    if (!i_Tx_Done && !i_Tx_Active) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
//==============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo. Includes a
//               behavioural downstream UART transmitter (4 clocks per bit,
//               done held for two cycles) that records each serial frame.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [7:0]      wr_byte = 8'h00;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            tx_dv;
    logic [7:0]      tx_byte;
    logic            tx_active = 1'b0;
    logic            tx_done = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Wr_En     (wr_en),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (overflow),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done)
    );

    // ---------------- downstream transmitter model ----------------
    logic       serial = 1'b1;
    logic       m_busy = 1'b0;
    logic [9:0] m_sh = '0;
    logic [9:0] m_frame = '0;
    int         m_cnt = 0;
    int         m_bit = 0;
    int         m_done_cnt = 0;
    int         dv_count = 0;
    int         viol = 0;
    logic [9:0] frames[$];

    always @(posedge clk) begin
        if (tx_dv) begin
            dv_count++;
            if (m_busy || tx_done) viol++;
        end
        if (m_done_cnt > 0) begin
            m_done_cnt <= m_done_cnt - 1;
        end else begin
            tx_done <= 1'b0;
        end
        if (!m_busy) begin
            if (tx_dv) begin
                m_busy    <= 1'b1;
                tx_active <= 1'b1;
                m_sh      <= {1'b1, tx_byte, 1'b0};
                serial    <= 1'b0;
                m_bit     <= 0;
                m_cnt     <= 0;
            end
        end else if (m_cnt == 3) begin
            m_cnt <= 0;
            m_frame[m_bit] <= serial;
            if (m_bit == 9) begin
                frames.push_back({serial, m_frame[8:0]});
                m_busy     <= 1'b0;
                tx_active  <= 1'b0;
                tx_done    <= 1'b1;
                m_done_cnt <= 1;
                serial     <= 1'b1;
            end else begin
                m_bit  <= m_bit + 1;
                serial <= m_sh[m_bit+1];
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait until n frames have been seen and the transmitter is quiet again,
    // then give the FIFO one more cycle to return to idle.
    task automatic wait_frames(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((frames.size() < n || tx_active || tx_done) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(frames.size()), 32'(n));
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        int peak;
        int dvc;
        int base;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_dv",    32'(tx_dv), 32'd0);
        chk("rst_byte",  32'(tx_byte), 32'h00);
        chk("rst_ovf",   32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte launch latency
        wr_en = 1'b1; wr_byte = 8'h41;
        @(negedge clk);                     // edge E has passed
        wr_en = 1'b0;
        chk("lat_dv_E",    32'(tx_dv), 32'd0);
        chk("lat_cnt_E",   32'(count), 32'd1);
        @(negedge clk);                     // E+1 has passed
        chk("lat_dv_E1",   32'(tx_dv), 32'd1);
        chk("lat_byte_E1", 32'(tx_byte), 32'h41);
        chk("lat_cnt_E1",  32'(count), 32'd0);
        @(negedge clk);                     // E+2 has passed
        chk("lat_dv_E2",   32'(tx_dv), 32'd0);
        wait_frames(1, 200, "single_timeout");
        chk("single_frame", 32'(frames[0]), 32'({1'b1, 8'h41, 1'b0}));
        chk("single_dvcnt", 32'(dv_count), 32'd1);

        // Burst of five
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_byte = 8'(i);
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
        end
        wr_en = 1'b0;
        k = 0;
        while ((frames.size() < 6 || tx_active || tx_done) && k < 1000) begin
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
            k++;
        end
        chk("burst_timeout", 32'(frames.size()), 32'd6);
        @(negedge clk);
        chk("burst_peak", 32'(peak), 32'd4);
        for (int i = 1; i <= 5; i++)
            chk($sformatf("burst_frame%0d", i), 32'(frames[i]), 32'({1'b1, 8'(i), 1'b0}));
        chk("burst_dvcnt", 32'(dv_count), 32'd6);
        chk("burst_viol",  32'(viol), 32'd0);

        // Overflow: DEPTH+2 writes, first one launches immediately
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_en = 1'b1; wr_byte = 8'(8'h10 + i);
            @(negedge clk);
            if (i == DEPTH) begin
                chk("ovf_full_at_cap", 32'(full), 32'd1);
                chk("ovf_flag_at_cap", 32'(overflow), 32'd0);
            end
        end
        wr_en = 1'b0;
        chk("ovf_full",  32'(full), 32'd1);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        chk("ovf_flag",  32'(overflow), 32'd1);

        // Keep writing while full until the pop: the coincident write is dropped
        k = 0;
        while (!tx_dv && k < 300) begin
            wr_en = 1'b1; wr_byte = 8'hEE;
            @(negedge clk);
            k++;
        end
        wr_en = 1'b0;
        chk("popfull_dv",    32'(tx_dv), 32'd1);
        chk("popfull_count", 32'(count), 32'(DEPTH - 1));
        chk("popfull_ovf",   32'(overflow), 32'd1);
        chk("popfull_byte",  32'(tx_byte), 32'h11);
        wait_frames(6 + DEPTH + 1, 3000, "ovf_drain_timeout");
        for (int i = 0; i <= DEPTH; i++)
            chk($sformatf("ovf_frame%0d", i), 32'(frames[6 + i]), 32'({1'b1, 8'(8'h10 + i), 1'b0}));
        chk("ovf_empty_end", 32'(empty), 32'd1);
        chk("ovf_held",      32'(overflow), 32'd1);
        chk("ovf_dvcnt",     32'(dv_count), 32'(6 + DEPTH + 1));

        // Reset mid-frame with three bytes queued
        base = frames.size();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_byte = 8'(8'hA1 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy",  32'(tx_active), 32'd1);
        chk("mid_count", 32'(count), 32'd3);
        rst_n = 1'b0; wr_en = 1'b1; wr_byte = 8'h55;
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b0;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_dv",    32'(tx_dv), 32'd0);
        chk("mrst_byte",  32'(tx_byte), 32'h00);
        chk("mrst_ovf",   32'(overflow), 32'd0);
        dvc = dv_count;
        k = 0;
        while ((tx_active || tx_done) && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        chk("mrst_no_dv",   32'(dv_count), 32'(dvc));
        chk("mrst_inflight", 32'(frames.size()), 32'(base + 1));
        chk("mrst_a1",      32'(frames[base]), 32'({1'b1, 8'hA1, 1'b0}));

        wr_en = 1'b1; wr_byte = 8'h7E;
        @(negedge clk);
        wr_en = 1'b0;
        wait_frames(base + 2, 300, "post_rst_timeout");
        chk("post_rst_frame", 32'(frames[base + 1]), 32'({1'b1, 8'h7E, 1'b0}));
        chk("post_rst_dvcnt", 32'(dv_count), 32'(dvc + 1));
        chk("final_viol",     32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
